// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and baud divider helper.
// Used by both receiver and transmitter so frame format stays in one place.
package uart_pkg;

    localparam int UART_OSR  = 16;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    function automatic int baud_div(input int f_clk, input int f_baud, input int osr);
        return f_clk / (f_baud * osr);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver line and byte-output bundle; slave side is the receiver itself.
// No handshake: done/frame_err are single-cycle pulses, rx_data holds.
interface uart_rx_os_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 done;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx, input rx_data, done, frame_err, busy);
    modport slave  (input rx, output rx_data, done, frame_err, busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick: one-cycle pulse every clk_freq/(baud_rate*OSR) clocks.
// Latency: restart zeroes the phase so the next tick lands a full period later; no backpressure.
module uart_baud_tick import uart_pkg::*; #(
    parameter int clk_freq  = 1536000,
    parameter int baud_rate = 9600,
    parameter int OSR       = UART_OSR
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int DIV = baud_div(clk_freq, baud_rate, OSR);
    localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_too_small
        $error("uart_baud_tick: clk_freq/(baud_rate*OSR) must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == LAST) && !restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling with false-start and break handling.
// Latency: done ~9.5 bit times + 3 clk after the start edge; no backpressure (pulse outputs).
module uart_rx_os import uart_pkg::*; #(
    parameter int clk_freq  = 1536000,
    parameter int baud_rate = 9600,
    parameter int OSR       = UART_OSR
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_os_if.slave  bus
);

    localparam int TW = $clog2(UART_OSR);
    localparam logic [TW-1:0] MID_TICK  = TW'(UART_OSR / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(UART_OSR - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    if (OSR != UART_OSR) begin : g_osr_fixed
        $error("uart_rx_os: only OSR = 16 is supported");
    end

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 rx_prev_q, rx_prev_d;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 done_q, done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    logic rx_s;
    logic start_edge;
    logic restart;
    logic tick;

    uart_baud_tick #(
        .clk_freq  (clk_freq),
        .baud_rate (baud_rate),
        .OSR       (OSR)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        sync1_d     = bus.rx;
        sync2_d     = sync1_q;
        rx_prev_d   = sync2_q;
        rx_s        = sync2_q;
        start_edge  = rx_prev_q & ~rx_s;
        restart     = 1'b0;
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                    restart    = 1'b1;
                end
            end
            RX_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                // tick_cnt wraps 15 -> 0, so each bit window starts at zero
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == LAST_TICK) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = RX_STOP;
                        end
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == LAST_TICK) begin
                        if (rx_s) begin
                            rx_data_d = shift_q;
                            done_d    = 1'b1;
                            state_d   = RX_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = RX_WAIT_IDLE;
                        end
                    end
                end
            end
            RX_WAIT_IDLE: begin
                // Any low sample restarts the 16-tick idle qualification
                if (!rx_s) begin
                    tick_cnt_d = '0;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == LAST_TICK) begin
                        state_d = RX_IDLE;
                    end
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        busy_d = (state_d != RX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= RX_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.done      = done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter: clk_freq, default 1536000, system clock frequency in Hz.
REQ-002 Parameter: baud_rate, default 9600, line bit rate in baud.
REQ-003 Parameter: OSR, default 16, oversampling ratio, fixed at 16 for this release.
REQ-004 Port: clk, input, 1, single system clock; all logic on rising edge.
REQ-005 Port: rst, input, 1, asynchronous active-high reset.
REQ-006 Port: rx, input, 1, asynchronous serial line; idle high, 8N1, LSB first.
REQ-007 Port: rx_data, output, 8, last correctly framed byte; held until the next good frame.
REQ-008 Port: done, output, 1, one-clk pulse when rx_data is updated.
REQ-009 Port: frame_err, output, 1, one-clk pulse when the stop bit is sampled low.
REQ-010 Port: busy, output, 1, high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; all references to rx below mean the synchronized value.
REQ-012 Tick generator SHALL assert a one-clk tick every DIV = clk_freq/(baud_rate*OSR) clocks (default 10); DIV SHALL be at least 2, enforced by an elaboration-time check.
REQ-013 The divider SHALL restart from zero when a start edge is detected, so that sampling is aligned to the frame.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE: a high-to-low transition on rx SHALL move the FSM to START and clear the tick count.
REQ-016 START: on the 8th tick (mid-bit), rx low SHALL move the FSM to DATA; rx high is a false start and SHALL return the FSM to IDLE with no output pulse.
REQ-017 DATA: every 16 ticks the FSM SHALL sample rx into the shift register, LSB first; after 8 samples it SHALL move to STOP.
REQ-018 STOP: after 16 ticks the FSM SHALL sample rx.
- If rx is high: rx_data SHALL load the shift register, done SHALL pulse on the same clk, and the FSM SHALL return to IDLE.
- If rx is low: frame_err SHALL pulse, rx_data SHALL be unchanged, and the FSM SHALL move to WAIT_IDLE.
REQ-019 WAIT_IDLE: the FSM SHALL stay until rx is high for 16 consecutive ticks, then go to IDLE; this covers line break.
REQ-020 done and frame_err SHALL never be asserted in the same clk.
REQ-021 Latency: done SHALL assert 9.5 bit times ±1 tick after the falling start edge, plus 2 clk synchronizer delay.
REQ-022 Back-to-back frames: a start edge arriving in the first clk after return to IDLE SHALL be accepted; no idle gap beyond the stop bit is required.
REQ-023 The receiver SHALL tolerate a ±3% baud mismatch over one frame without bit errors.

Reset
REQ-024 While rst is high, rx_data, done, frame_err and busy SHALL be 0, the FSM SHALL be in IDLE, and the counters and shift register SHALL be 0.
REQ-025 The synchronizer flops SHALL reset to 1 (line idle) so that reset release does not create a false start.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done or frame_err pulse; reception resumes from the next start edge after release.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state enum type, OSR, and the shared frame constants (DATA_BITS = 8, STOP_BITS = 1).
REQ-028 Sub-module uart_baud_tick (parameters clk_freq, baud_rate, OSR; ports clk, rst, restart, tick) SHALL implement the tick generator; it is reusable by the transmitter.

Verification
REQ-029 Send 0xA5 at 9600 8N1 -> rx_data = 0xA5, exactly one done pulse, frame_err stays 0, busy low afterwards.
REQ-030 Drive a 4-tick low glitch on idle rx -> no done, no frame_err, rx_data unchanged, FSM back in IDLE.
REQ-031 Send 0x3C with the stop bit forced low -> one frame_err pulse, rx_data keeps its prior value 0xA5; hold rx low for 2 frames, then release -> FSM returns to IDLE only after 16 high ticks.
REQ-032 Send back-to-back 0x00 then 0xFF with no idle gap -> two done pulses; rx_data = 0x00, then 0xFF.
REQ-033 Assert rst during bit 4 of 0x55, release, then send 0x81 -> no pulse for the aborted frame; rx_data = 0x81.
REQ-034 Send 0x6E with the transmitter baud at +3% and then at -3% -> rx_data = 0x6E both times, no frame_err.
